// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : multi-cycle ALU with a Start/Busy/Done handshake.
//   Logic, add/sub and compare ops complete on the accepting edge.
//   MUL runs shift-add, one multiplier bit per clock, for WIDTH clocks.
//
// Ports
//   CLK           rising-edge clock
//   RST           asynchronous active-low reset
//   Start         request, sampled only while Busy=0
//   A, B          operands, latched on the accepting edge
//   ALU_FUNC      opcode, latched with the operands
//   ALU_OUT       registered result, held until the next completion
//   Zero_Flag     registered, set when the newly written ALU_OUT is 0
//   Overflow_Flag registered overflow of the last completed operation
//   Busy          high while a multiply is in flight
//   Done          one-cycle completion pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready; single-cycle ops complete here, MUL loads and leaves
// MUL_RUN | shift-add iterations in progress, Start ignored
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_FUNC,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             Zero_Flag,
  output logic             Overflow_Flag,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   res_d;
  logic               ovf_d;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_d;

  assign sum  = A + B;
  assign diff = A - B;

  // The multiplicand register is pre-shifted each step, so adding it
  // directly is the "shifted by iteration index" partial product.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (ALU_FUNC)
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_ADD: begin
        res_d = sum;
        ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (A < B)};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
      ALU_OUT       <= '0;
      Zero_Flag     <= 1'b1;
      Overflow_Flag <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (ALU_FUNC == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, A};
              mplier_q <= B;
              cnt_q    <= CW'(WIDTH);
              Busy     <= 1'b1;
              state_q  <= MUL_RUN;
            end else begin
              ALU_OUT       <= res_d;
              Zero_Flag     <= (res_d == '0);
              Overflow_Flag <= ovf_d;
              Done          <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            ALU_OUT       <= acc_d[WIDTH-1:0];
            Zero_Flag     <= (acc_d[WIDTH-1:0] == '0);
            Overflow_Flag <= |acc_d[2*WIDTH-1:WIDTH];
            Done          <= 1'b1;
            Busy          <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALU_FUNC;
  logic [W-1:0] ALU_OUT;
  logic         Zero_Flag;
  logic         Overflow_Flag;
  logic         Busy;
  logic         Done;

  seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
    .ALU_OUT(ALU_OUT), .Zero_Flag(Zero_Flag), .Overflow_Flag(Overflow_Flag),
    .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: whenever Done is seen, pop the oldest expectation and compare.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(ALU_OUT), 64'(e.res));
        chk("zero_flag", 64'(Zero_Flag), 64'(e.z));
        chk("ovf_flag", 64'(Overflow_Flag), 64'(e.o));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Drives a request at the next negedge; lat is the number of edges from
  // this negedge until Done is observed (1 for single-cycle, W+1 for MUL).
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] res, input logic z, input logic o);
    exp_t e;
    @(negedge CLK);
    Start    = 1'b1;
    ALU_FUNC = f;
    A        = a;
    B        = b;
    e.res = res; e.z = z; e.o = o; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge CLK);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_out"}, 64'(ALU_OUT), 64'd0);
    chk({tag, "_zero"}, 64'(Zero_Flag), 64'd1);
    chk({tag, "_ovf"}, 64'(Overflow_Flag), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
    chk({tag, "_done"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int bc;
    Start = 1'b0; A = '0; B = '0; ALU_FUNC = 3'b000;
    RST = 1'b1;
    #1 RST = 1'b0;

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      Start    = 1'($urandom_range(0, 1));
      A        = $urandom;
      B        = $urandom;
      ALU_FUNC = 3'($urandom_range(0, 7));
      #1 chk_reset_outputs("reset");
    end
    @(negedge CLK);
    Start = 1'b0;
    RST   = 1'b1;

    // Signed overflow on ADD.
    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0, 1'b1);
    idle();
    drain();

    // Back-to-back single-cycle ops.
    issue(3'b100, 32'd5, 32'd5, 1, 32'd0, 1'b1, 1'b0);
    issue(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'd1, 1'b0, 1'b0);
    issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'd0, 1'b1, 1'b0);
    issue(3'b011, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'h0F0F_F0F0, 1'b0, 1'b0);
    idle();
    drain();

    // MUL with ignored Starts while Busy.
    issue(3'b101, 32'd12345, 32'd678, W + 1, 32'd8369910, 1'b0, 1'b0);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Busy !== 1'b1) break;
      bc++;
      if (i == 10) chk("alu_out_hold_during_mul", 64'(ALU_OUT), 64'h0F0F_F0F0);
      Start    = (i >= 2 && i < 6);
      ALU_FUNC = 3'b010;
      A        = 32'd1;
      B        = 32'd1;
    end
    Start = 1'b0;
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    drain();

    // MUL whose low half is zero and high half nonzero.
    issue(3'b101, 32'h0001_0000, 32'h0001_0000, W + 1, 32'd0, 1'b1, 1'b1);
    idle();
    drain();

    // Abort a MUL with reset ten cycles in.
    issue(3'b101, 32'd3, 32'd5, W + 1, 32'd15, 1'b0, 1'b0);
    idle();
    repeat (9) @(negedge CLK);
    chk("busy_before_abort", 64'(Busy), 64'd1);
    RST = 1'b0;
    #1 chk_reset_outputs("abort");
    sb.delete();
    @(negedge CLK);
    chk("abort_hold_done", 64'(Done), 64'd0);
    RST = 1'b1;

    // Recovery.
    issue(3'b010, 32'd3, 32'd4, 1, 32'd7, 1'b0, 1'b0);
    idle();
    drain();
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
